// File: rtl/mode_stopwatch_lap.sv
// Stopwatch LCD mode: BCD time with run/pause/idle control,
// circular lap memory browsable in pause, and sticky overflow.
module mode_stopwatch_lap #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int MAX_MIN   = 59
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_start,
    input  logic                           btn_lap,
    input  logic                           btn_clr,
    input  logic [4:0]                     index,
    output logic [7:0]                     out,
    output logic                           running,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PSW = $clog2(DIV);
    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [3:0] MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MO = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t              state;
    logic [PSW-1:0]      presc;
    logic [5:0][3:0]     t;
    logic [5:0][3:0]     t_inc;
    logic [5:0][3:0]     shown;
    logic                wrap;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       view_sel;
    logic [23:0]         lap_mem [LAP_DEPTH];
    logic                tick;
    logic                do_clr;
    logic                do_start;
    logic                do_lap;
    logic [47:0]         status;
    logic [0:31][7:0]    line;
    int                  slot;

    assign tick     = (state == RUN) && (presc == PSW'(DIV - 1));
    assign do_clr   = btn_clr && (state != RUN);
    assign do_start = btn_start && !do_clr;
    assign do_lap   = btn_lap && !btn_start && !do_clr;

    // Digit order: [0]=cc ones ... [5]=mm tens
    always_comb begin
        t_inc = t;
        wrap  = 1'b0;
        if (t[0] != 4'd9) t_inc[0] = t[0] + 4'd1;
        else begin
            t_inc[0] = 4'd0;
            if (t[1] != 4'd9) t_inc[1] = t[1] + 4'd1;
            else begin
                t_inc[1] = 4'd0;
                if (t[2] != 4'd9) t_inc[2] = t[2] + 4'd1;
                else begin
                    t_inc[2] = 4'd0;
                    if (t[3] != 4'd5) t_inc[3] = t[3] + 4'd1;
                    else begin
                        t_inc[3] = 4'd0;
                        if (t[5] == MT && t[4] == MO) begin
                            t_inc[5] = 4'd0;
                            t_inc[4] = 4'd0;
                            wrap     = 1'b1;
                        end else if (t[4] != 4'd9) begin
                            t_inc[4] = t[4] + 4'd1;
                        end else begin
                            t_inc[4] = 4'd0;
                            t_inc[5] = t[5] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Lap k maps to slot oldest+k-1; bias keeps the sum non-negative
    always_comb begin
        slot  = (int'(wr_ptr) + 2 * LAP_DEPTH - int'(lap_count)
                 + int'(view_sel) - 1) % LAP_DEPTH;
        shown = t;
        if (state == PAUSE && view_sel != '0) shown = lap_mem[PW'(slot)];
        status = "READY ";
        unique case (state)
            IDLE:    status = "READY ";
            RUN:     status = "RUN   ";
            PAUSE:   status = (view_sel == '0) ? "STOP  " :
                              {"LAP ", 8'h30 + 8'(view_sel), 8'h20};
            default: status = "READY ";
        endcase
        line = {"Stopwatch ", status, "TIME ",
                {4'h3, shown[5]}, {4'h3, shown[4]}, ":",
                {4'h3, shown[3]}, {4'h3, shown[2]}, ":",
                {4'h3, shown[1]}, {4'h3, shown[0]}, " ",
                ovf ? "O" : " ", " "};
    end

    always_ff @(posedge clk) begin
        if (do_lap && state == RUN) lap_mem[wr_ptr] <= t;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            t         <= '0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            lap_count <= '0;
            view_sel  <= '0;
            running   <= 1'b0;
            out       <= 8'h20;
        end else begin
            if (state == RUN && !do_start) presc <= tick ? '0 : presc + 1'b1;
            else                           presc <= '0;
            if (tick) begin
                t <= t_inc;
                if (wrap) ovf <= 1'b1;
            end
            if (do_clr) begin
                state     <= IDLE;
                running   <= 1'b0;
                t         <= '0;
                ovf       <= 1'b0;
                wr_ptr    <= '0;
                lap_count <= '0;
                view_sel  <= '0;
            end else if (do_start) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else begin
                    state    <= RUN;
                    running  <= 1'b1;
                    view_sel <= '0;
                end
            end else if (do_lap) begin
                if (state == RUN) begin
                    wr_ptr <= (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                    if (lap_count != CW'(LAP_DEPTH)) lap_count <= lap_count + 1'b1;
                end else if (state == PAUSE) begin
                    view_sel <= (view_sel == lap_count) ? '0 : view_sel + 1'b1;
                end
            end
            out <= line[index];
        end
    end

endmodule
